simple_cpu_mc: RTL and testbench

Parametrised multi-cycle successor to `simple_cpu`. It takes one instruction at a time over a valid/ready handshake and executes it through a decode/execute/memory/write-back state machine. It holds a `REG_COUNT`-entry register file and a `2**ADDR_BITS`-word data memory, supports an extended ALU/immediate/load/store instruction set with zero and carry flags, and exposes registers through a debug read port instead of fixed per-register outputs.

---
 rtl/simple_cpu_mc.sv | 213 +++++++++++++++++++++
 tb/tb_simple_cpu_mc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/simple_cpu_mc.sv
// simple_cpu_mc: multi-cycle core with register file, data memory, ALU flags
// and a debug register read port. One instruction in flight at a time.
module simple_cpu_mc #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned REG_COUNT   = 8,
  parameter int unsigned INSTR_WIDTH = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          instr_valid,
  input  logic [INSTR_WIDTH-1:0]        instr,
  output logic                          instr_ready,
  output logic                          done,
  output logic                          err,
  output logic                          flag_zero,
  output logic                          flag_carry,
  input  logic [$clog2(REG_COUNT)-1:0]  dbg_sel,
  output logic [DATA_WIDTH-1:0]         dbg_data
);

  localparam int unsigned RB      = $clog2(REG_COUNT);
  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam int unsigned SW      = (DATA_WIDTH > ADDR_BITS) ? DATA_WIDTH : ADDR_BITS;
  localparam int unsigned RD_LSB  = INSTR_WIDTH - 4 - RB;
  localparam int unsigned RS1_LSB = RD_LSB - RB;
  localparam int unsigned RS2_LSB = RS1_LSB - RB;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_LDI   = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_NOP   = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t                  state;
  logic [INSTR_WIDTH-1:0]  instr_q;
  logic [3:0]              op_q;
  logic [RB-1:0]           rd_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [ADDR_BITS-1:0]    imm_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    wr_en_q;

  logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
  logic [DATA_WIDTH-1:0]   mem  [DEPTH];

  logic [3:0]              op_f;
  logic [RB-1:0]           rd_f;
  logic [RB-1:0]           rs1_f;
  logic [RB-1:0]           rs2_f;
  logic [ADDR_BITS-1:0]    imm_f;
  logic                    unused_instr_bits;

  logic [DATA_WIDTH:0]     sum_c;
  logic [DATA_WIDTH:0]     diff_c;
  logic                    shift_big_c;
  logic [ADDR_BITS-1:0]    addr_c;
  logic [DATA_WIDTH-1:0]   alu_res_c;
  logic                    alu_carry_c;

  // Field extraction from the latched instruction word
  assign op_f  = instr_q[INSTR_WIDTH-1 -: 4];
  assign rd_f  = instr_q[RD_LSB  +: RB];
  assign rs1_f = instr_q[RS1_LSB +: RB];
  assign rs2_f = instr_q[RS2_LSB +: RB];
  assign imm_f = instr_q[ADDR_BITS-1:0];
  assign unused_instr_bits = ^instr_q;

  assign dbg_data = regs[dbg_sel];

  // Datapath helpers; the extra MSB of sum/diff is carry-out / borrow
  assign sum_c       = {1'b0, a_q} + {1'b0, b_q};
  assign diff_c      = {1'b0, a_q} - {1'b0, b_q};
  assign shift_big_c = 32'(imm_q) >= DATA_WIDTH;
  assign addr_c      = ADDR_BITS'(SW'(a_q) + SW'(imm_q));

  // ALU result and carry for the operation held in op_q
  always_comb begin
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    case (op_q)
      OP_ADD: {alu_carry_c, alu_res_c} = sum_c;
      OP_SUB: {alu_carry_c, alu_res_c} = diff_c;
      OP_AND: alu_res_c = a_q & b_q;
      OP_OR:  alu_res_c = a_q | b_q;
      OP_XOR: alu_res_c = a_q ^ b_q;
      OP_SHL: alu_res_c = shift_big_c ? '0 : (a_q << imm_q);
      OP_SHR: alu_res_c = shift_big_c ? '0 : (a_q >> imm_q);
      OP_LDI: alu_res_c = DATA_WIDTH'(imm_q);
      default: ;
    endcase
  end

  // Control FSM with registered handshake, completion pulse and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      flag_zero   <= 1'b0;
      flag_carry  <= 1'b0;
      instr_q     <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      addr_q      <= '0;
      result_q    <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_q    <= op_f;
          rd_q    <= rd_f;
          a_q     <= regs[rs1_f];
          b_q     <= regs[rs2_f];
          imm_q   <= imm_f;
          wr_en_q <= 1'b0;
          if (op_f > OP_NOP) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_WB;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q == OP_LOAD || op_q == OP_STORE) begin
            addr_q <= addr_c;
            state  <= S_MEM;
          end else begin
            result_q <= alu_res_c;
            wr_en_q  <= (op_q <= OP_LDI);
            if (op_q <= OP_SHR) begin
              flag_zero  <= (alu_res_c == '0);
              flag_carry <= alu_carry_c;
            end
            done  <= 1'b1;
            state <= S_WB;
          end
        end
        S_MEM: begin
          // Read of the address latched in EXEC; stores commit on this edge
          if (op_q == OP_LOAD) begin
            result_q <= mem[addr_q];
            wr_en_q  <= 1'b1;
          end
          done  <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          wr_en_q     <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: reset to index values, written on the WB edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= DATA_WIDTH'(i);
      end
    end else if (state == S_WB && wr_en_q) begin
      regs[rd_q] <= result_q;
    end
  end

  // Data memory: cleared on reset, store committed on the MEM edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == S_MEM && op_q == OP_STORE) begin
      mem[addr_q] <= b_q;
    end
  end

endmodule

// File: tb/tb_simple_cpu_mc.sv
// Scoreboard bench for simple_cpu_mc: stimulus pushes hand-computed
// expectations, a monitor checks them whenever done pulses.
`timescale 1ns/1ps
module tb_simple_cpu_mc;

  typedef struct packed {
    logic [31:0]     done_cyc;
    logic            is_state;
    logic            e_err;
    logic            e_z;
    logic            e_c;
    logic [7:0][7:0] regs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [19:0] instr;
  logic        instr_ready;
  logic        done;
  logic        err;
  logic        flag_zero;
  logic        flag_carry;
  logic [2:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int unsigned     cyc = 0;
  int unsigned     checks = 0;
  int unsigned     errors = 0;
  exp_t            sb_q[$];
  logic [7:0][7:0] model;
  bit              have_prev = 1'b0;
  int unsigned     prev_e0 = 0;
  int unsigned     prev_off = 0;

  simple_cpu_mc dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .done        (done),
    .err         (err),
    .flag_zero   (flag_zero),
    .flag_carry  (flag_carry),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [4:0] imm);
    return {op, rd, rs1, rs2, 2'b00, imm};
  endfunction

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic scan(input logic [7:0][7:0] r);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      chk($sformatf("reg%0d", i), 32'(dbg_data), 32'(r[i]));
    end
  endtask

  // Monitor: pops one expectation per done pulse, or per queued state check
  initial begin
    exp_t e;
    dbg_sel = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("err", 32'(err), 32'(e.e_err));
          chk("flag_zero", 32'(flag_zero), 32'(e.e_z));
          chk("flag_carry", 32'(flag_carry), 32'(e.e_c));
          chk("ready_busy", 32'(instr_ready), 32'd0);
          @(negedge clk);
          chk("done_pulse", 32'(done), 32'd0);
          chk("err_pulse", 32'(err), 32'd0);
          chk("ready_idle", 32'(instr_ready), 32'd1);
          scan(e.regs);
        end
      end else if (rst === 1'b1 && sb_q.size() != 0 && sb_q[0].is_state) begin
        e = sb_q.pop_front();
        chk("st_ready", 32'(instr_ready), 32'd1);
        chk("st_done", 32'(done), 32'd0);
        chk("st_err", 32'(err), 32'd0);
        chk("st_zero", 32'(flag_zero), 32'(e.e_z));
        chk("st_carry", 32'(flag_carry), 32'(e.e_c));
        scan(e.regs);
      end
    end
  end

  task automatic push_state(input bit z, input bit c);
    exp_t e;
    e.done_cyc = '0;
    e.is_state = 1'b1;
    e.e_err    = 1'b0;
    e.e_z      = z;
    e.e_c      = c;
    e.regs     = model;
    sb_q.push_back(e);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) model[i] = 8'(i);
    have_prev = 1'b0;
  endtask

  // Present an instruction, hold it until accepted, queue its expectation
  task automatic issue(input logic [19:0] w, input int unsigned off, input bit e_err,
                       input bit e_z, input bit e_c, input bit wr, input int unsigned rd,
                       input logic [7:0] val, input bit push, output int unsigned e0);
    exp_t e;
    int unsigned n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) chk("accept_timeout", 32'(instr_ready), 32'd1);
    e0 = have_prev ? prev_e0 + prev_off + 2 : cyc + 1;
    if (push) begin
      if (wr) model[rd] = val;
      e.done_cyc = e0 + off;
      e.is_state = 1'b0;
      e.e_err    = e_err;
      e.e_z      = e_z;
      e.e_c      = e_c;
      e.regs     = model;
      sb_q.push_back(e);
      prev_e0   = e0;
      prev_off  = off;
      have_prev = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
  endtask

  // Stimulus: directed instruction stream with hand-computed results
  initial begin
    int unsigned e0;
    rst = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_state(1'b0, 1'b0);
    drain();

    //     op  rd rs1 rs2 imm          off err z  c  wr rd val
    issue(enc(0, 0, 1, 3, 0),  2, 0, 0, 0, 1, 0, 8'd4,   1, e0);
    issue(enc(1, 3, 2, 5, 0),  2, 0, 0, 1, 1, 3, 8'd253, 1, e0);
    issue(enc(9, 0, 2, 1, 15), 3, 0, 0, 1, 0, 0, 8'd0,   1, e0);
    issue(enc(8, 3, 2, 0, 15), 3, 0, 0, 1, 1, 3, 8'd1,   1, e0);
    issue(enc(7, 7, 0, 0, 30), 2, 0, 0, 1, 1, 7, 8'd30,  1, e0);
    issue(enc(9, 0, 7, 4, 7),  3, 0, 0, 1, 0, 0, 8'd0,   1, e0);
    issue(enc(8, 6, 0, 0, 1),  3, 0, 0, 1, 1, 6, 8'd4,   1, e0);
    issue(enc(13, 2, 1, 1, 3), 1, 1, 0, 1, 0, 0, 8'd0,   1, e0);
    issue(enc(5, 5, 7, 0, 9),  2, 0, 1, 0, 1, 5, 8'd0,   1, e0);
    issue(enc(2, 1, 0, 7, 0),  2, 0, 0, 0, 1, 1, 8'd4,   1, e0);
    issue(enc(3, 2, 3, 7, 0),  2, 0, 0, 0, 1, 2, 8'd31,  1, e0);
    issue(enc(4, 4, 2, 7, 0),  2, 0, 0, 0, 1, 4, 8'd1,   1, e0);
    issue(enc(6, 0, 7, 0, 2),  2, 0, 0, 0, 1, 0, 8'd7,   1, e0);
    issue(enc(1, 5, 5, 4, 0),  2, 0, 0, 1, 1, 5, 8'd255, 1, e0);
    issue(enc(0, 6, 5, 4, 0),  2, 0, 1, 1, 1, 6, 8'd0,   1, e0);
    issue(enc(0, 5, 5, 5, 0),  2, 0, 0, 1, 1, 5, 8'd254, 1, e0);
    issue(enc(6, 3, 5, 0, 8),  2, 0, 1, 0, 1, 3, 8'd0,   1, e0);
    issue(enc(10, 1, 1, 1, 1), 2, 0, 1, 0, 0, 0, 8'd0,   1, e0);
    issue(enc(5, 2, 4, 0, 7),  2, 0, 0, 0, 1, 2, 8'd128, 1, e0);
    issue(enc(7, 1, 0, 0, 17), 2, 0, 0, 0, 1, 1, 8'd17,  1, e0);
    issue(enc(1, 0, 1, 1, 0),  2, 0, 1, 0, 1, 0, 8'd0,   1, e0);

    // LOAD killed by reset while in MEM: nothing may be written
    issue(enc(8, 7, 0, 0, 5),  3, 0, 0, 0, 1, 7, 8'd4,   0, e0);
    instr_valid = 1'b0;
    while (cyc < e0 + 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    push_state(1'b0, 1'b0);
    drain();

    // Memory must read back cleared after reset
    issue(enc(8, 3, 0, 0, 5),  3, 0, 0, 0, 1, 3, 8'd0,   1, e0);
    issue(enc(8, 4, 2, 0, 15), 3, 0, 0, 0, 1, 4, 8'd0,   1, e0);
    issue(enc(0, 1, 7, 6, 0),  2, 0, 0, 0, 1, 1, 8'd13,  1, e0);
    instr_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    chk("watchdog", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
